// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and parameter legality checks for the synchronous FIFO
package fifo_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int aw);
    return aw + 1;
  endfunction
  function automatic bit thresh_ok(input int af, input int ae, input int depth);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction
endpackage

// File: rtl/fifo_regfile.sv
// fifo_regfile: DATA_WIDTH x DEPTH storage, synchronous write, asynchronous read
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with count, thresholds, error pulses,
// synchronous flush and selectable standard / first-word-fall-through read
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH = (1 << ADDR_WIDTH) - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW = cnt_w(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);

  if (!thresh_ok(AF_THRESH, AE_THRESH, DEPTH)) begin : g_bad_thresh
    $fatal(1, "fifo_sync_param: AF_THRESH or AE_THRESH out of range");
  end

  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [CW-1:0]         cnt_nxt;
  logic [DATA_WIDTH-1:0] rd_word, r_q;
  logic                  wr_acc, rd_acc;

  // Accepts judged on the registered flags, so a full FIFO never writes through.
  always_comb begin
    wr_acc = wr & ~full;
    rd_acc = rd & ~empty;
    cnt_nxt = clr ? '0 :
              (wr_acc && !rd_acc) ? count + 1'b1 :
              (rd_acc && !wr_acc) ? count - 1'b1 : count;
    r_data = (FWFT != 0) ? (empty ? '0 : rd_word) : r_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      r_q <= '0;
    end else begin
      wptr <= clr ? '0 : wptr + ADDR_WIDTH'(wr_acc);
      rptr <= clr ? '0 : rptr + ADDR_WIDTH'(rd_acc);
      count <= cnt_nxt;
      empty <= cnt_nxt == '0;
      full <= cnt_nxt == DEPTH_C;
      almost_empty <= cnt_nxt <= AE_C;
      almost_full <= cnt_nxt >= AF_C;
      overflow <= ~clr & wr & full;
      underflow <= ~clr & rd & empty;
      if (!clr && rd_acc) r_q <= rd_word;
    end

  fifo_regfile #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .we    (wr_acc & ~clr),
    .waddr (wptr),
    .wdata (w_data),
    .raddr (rptr),
    .rdata (rd_word)
  );
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: queue model checked every cycle against a standard and an FWFT instance
module tb_fifo_sync_param;
  logic clk = 0, reset = 0, clr = 0, wr = 0, rd = 0;
  logic [7:0] w_data = 0;
  logic a_full, a_af, a_empty, a_ae, a_ovf, a_unf;
  logic b_full, b_af, b_empty, b_ae, b_ovf, b_unf;
  logic [7:0] a_rdata, b_rdata;
  logic [2:0] a_count, b_count;
  int compared = 0, mism = 0;
  logic [7:0] q[$];
  logic [7:0] m_rq = 0;
  logic m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .full(a_full),
    .almost_full(a_af), .rd(rd), .r_data(a_rdata), .empty(a_empty), .almost_empty(a_ae),
    .count(a_count), .overflow(a_ovf), .underflow(a_unf));

  fifo_sync_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)) u_fw (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .full(b_full),
    .almost_full(b_af), .rd(rd), .r_data(b_rdata), .empty(b_empty), .almost_empty(b_ae),
    .count(b_count), .overflow(b_ovf), .underflow(b_unf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words plus the last word popped.
  always @(posedge clk or negedge reset) begin
    logic f;
    if (!reset) begin
      q.delete();
      m_rq = 0;
      m_ovf = 0;
      m_unf = 0;
    end else if (clr) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      f = (q.size() == 4);
      m_ovf = wr && f;
      m_unf = rd && (q.size() == 0);
      if (rd && q.size() != 0) m_rq = q.pop_front();
      if (wr && !f) q.push_back(w_data);
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("a_count", a_count, n);
    chk("a_empty", a_empty, n == 0);
    chk("a_full", a_full, n == 4);
    chk("a_af", a_af, n >= 3);
    chk("a_ae", a_ae, n <= 1);
    chk("a_ovf", a_ovf, m_ovf);
    chk("a_unf", a_unf, m_unf);
    chk("a_rdata", a_rdata, m_rq);
    chk("b_count", b_count, n);
    chk("b_empty", b_empty, n == 0);
    chk("b_full", b_full, n == 4);
    chk("b_af", b_af, n >= 3);
    chk("b_ae", b_ae, n <= 1);
    chk("b_ovf", b_ovf, m_ovf);
    chk("b_unf", b_unf, m_unf);
    if (n != 0) chk("b_rdata", b_rdata, q[0]);
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    wr = w;
    rd = r;
    clr = c;
    w_data = d;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] v3 [4];
    v3 = '{8'h11, 8'h22, 8'h33, 8'h44};
    repeat (2) @(negedge clk);
    reset = 1;
    step(1, 0, 0, 8'h12);
    step(1, 0, 0, 8'h34);
    chk("s1_cnt_pre", a_count, 2);
    #2 reset = 0;
    #1;
    chk("s1_async_empty", a_empty, 1);
    chk("s1_async_count", a_count, 0);
    chk("s1_async_rdata", a_rdata, 0);
    chk("s1_async_b_count", b_count, 0);
    #1 reset = 1;
    step(0, 1, 0, 8'h00);
    chk("s1_unf", a_unf, 1);
    step(0, 0, 0, 8'h00);
    chk("s1_unf_end", a_unf, 0);
    step(1, 0, 0, 8'hAA);
    chk("s2_cnt1", a_count, 1);
    step(1, 0, 0, 8'h55);
    chk("s2_cnt2", a_count, 2);
    step(0, 1, 0, 8'h00);
    chk("s2_rd1", a_rdata, 8'hAA);
    chk("s2_cnt3", a_count, 1);
    step(0, 1, 0, 8'h00);
    chk("s2_rd2", a_rdata, 8'h55);
    chk("s2_cnt4", a_count, 0);
    chk("s2_empty", a_empty, 1);
    chk("s2_ae", a_ae, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, v3[i]);
      if (i == 2) begin
        chk("s3_af3", a_af, 1);
        chk("s3_nfull3", a_full, 0);
      end
    end
    chk("s3_full", a_full, 1);
    chk("s3_cnt4", a_count, 4);
    step(1, 0, 0, 8'h55);
    chk("s3_ovf", a_ovf, 1);
    chk("s3_cnt_hold", a_count, 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'h00);
      chk("s3_rd", a_rdata, v3[i]);
    end
    step(1, 0, 0, 8'h01);
    step(1, 0, 0, 8'h02);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'(8'h03 + i));
      chk("s4_cnt2", a_count, 2);
      chk("s4_rd", a_rdata, 8'(8'h01 + i));
    end
    step(0, 1, 0, 8'h00);
    chk("s4_drain1", a_rdata, 8'h04);
    step(0, 1, 0, 8'h00);
    chk("s4_drain2", a_rdata, 8'h05);
    step(1, 1, 0, 8'h66);
    chk("s4_empty_cnt", a_count, 1);
    chk("s4_empty_unf", a_unf, 1);
    step(1, 0, 0, 8'h67);
    step(1, 0, 0, 8'h68);
    step(1, 0, 0, 8'h69);
    chk("s4_full", a_full, 1);
    step(1, 1, 0, 8'h70);
    chk("s4_full_cnt", a_count, 3);
    chk("s4_full_ovf", a_ovf, 1);
    chk("s4_full_rd", a_rdata, 8'h66);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 8'h00);
      chk("s4_tail", a_rdata, 8'(8'h67 + i));
    end
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h01);
    for (int i = 2; i < 10; i++) begin
      step(1, 1, 0, 8'(i));
      chk("s5_rd", a_rdata, i - 2);
    end
    step(0, 1, 0, 8'h00);
    chk("s5_rd8", a_rdata, 8'h08);
    step(0, 1, 0, 8'h00);
    chk("s5_rd9", a_rdata, 8'h09);
    chk("s5_empty", a_empty, 1);
    step(1, 0, 0, 8'hAA);
    chk("s6_fwft_head", b_rdata, 8'hAA);
    chk("s6_std_hold", a_rdata, 8'h09);
    step(1, 0, 1, 8'hBB);
    chk("s6_clr_cnt", b_count, 0);
    chk("s6_clr_empty", b_empty, 1);
    chk("s6_clr_std_rdata", a_rdata, 8'h09);
    step(1, 0, 0, 8'hCC);
    chk("s6_after_clr", b_rdata, 8'hCC);
    chk("s6_after_cnt", b_count, 1);
    step(0, 1, 0, 8'h00);
    chk("s6_std_rd", a_rdata, 8'hCC);
    chk("s6_end_empty", b_empty, 1);
    repeat (2) step(0, 0, 0, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised single-clock synchronous FIFO. Successor to the fixed 8-bit FIFO.
- Adds configurable width and depth, an occupancy count, almost-full and almost-empty thresholds, overflow and underflow pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer blocks (UART RX/TX paths, data buffering) in the memory task area.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH.
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH (legal range 1..DEPTH).
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (legal range 0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous flush, active-high.
- wr  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- full  out  1  FIFO holds DEPTH words.
- almost_full  out  1  count >= AF_THRESH.
- rd  in  1  read request.
- r_data  out  DATA_WIDTH  read data.
- empty  out  1  FIFO holds 0 words.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write dropped.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:

Clock and reset (already decided):
- One clock, clk.
- Reset is asynchronous and active-low, port named reset.
- While reset=0: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, r_data=0.
- Storage array is not reset.
- Reset asserted mid-operation discards all contents immediately, without waiting for a clock edge.

Accept rules:
- wr_acc = wr & ~full.
- rd_acc = rd & ~empty.
- Judged on flag values before the edge. There is no write-through when full.

Pointer and count update:
- On wr_acc: mem[wptr] <= w_data, wptr increments.
- On rd_acc: rptr increments.
- Pointers wrap modulo DEPTH.
- count +1 on write only, -1 on read only, unchanged when both are accepted.

Flags:
- All flags and count are registered.
- Each is computed from next-count, so all update on the same edge as count.
- full = (count==DEPTH); empty = (count==0).

Error pulses:
- Write when full: dropped. overflow is high for exactly the next cycle. State unchanged except for any accepted read.
- Read when empty: rejected. underflow is high for exactly the next cycle. r_data holds.

Simultaneous events:
- full & wr & rd: read accepted, write dropped, overflow pulse, count becomes DEPTH-1.
- empty & wr & rd: write accepted, read rejected, underflow pulse, count becomes 1.

FWFT=0 (standard read):
- On rd_acc, r_data <= mem[rptr] at that edge, so data is valid the cycle after rd.
- r_data holds its value otherwise.

FWFT=1 (first-word-fall-through):
- r_data = mem[rptr] combinationally whenever empty=0; rd pops the word.
- Head word is visible the cycle after its write edge.
- r_data is don't-care while empty.

clr:
- Priority over wr and rd.
- At the edge: pointers=0, count=0, flags take their reset values, no pulses.
- r_data holds in FWFT=0.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 function;
  - count-width helper (ADDR_WIDTH+1);
  - parameter-legality checks (AF_THRESH and AE_THRESH in range), fatal at elaboration.
- One natural sub-module: fifo_regfile.
  - Parametrised DATA_WIDTH x DEPTH storage.
  - Synchronous write port; asynchronous read port addressed by rptr.
- Pointer, count, flag and read-mode logic stays in fifo_sync_param.

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AF_THRESH=3, AE_THRESH=1, FWFT=0 unless stated.
1. Reset: write 0x12, 0x34, then pull reset=0 between edges -> empty=1, count=0, r_data=0 immediately. After release, a rd gives underflow=1 for one cycle.
2. Basic order: write 0xAA then 0x55, then rd for two cycles -> r_data=0xAA after the first read edge, 0x55 after the second. empty=1 and almost_empty=1 after the second read edge; count sequence 1,2,1,0.
3. Full/overflow: write 0x11, 0x22, 0x33, 0x44 -> almost_full=1 at count=3, full=1 at count=4. Fifth write of 0x55 -> overflow pulse, count stays 4. Read-out gives 0x11..0x44; 0x55 never appears.
4. Simultaneous: at count=2, wr=rd=1 for 3 cycles -> count stays 2, data order preserved. At empty, wr=rd=1 -> count=1, underflow pulse. At full, wr=rd=1 -> count=3, overflow pulse.
5. Wrap-around: stream 0x00..0x09 with concurrent wr/rd, occupancy 1..3 -> all 10 words read in order, no pulses, pointers wrap twice.
6. FWFT=1 instance: write 0xAA -> r_data=0xAA the cycle after the write edge with rd=0. Then write 0xBB and assert clr with wr=1 -> count=0, empty=1, and 0xBB is not stored.
